// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch/decode path.
// Instruction word width and the decode filler instruction.
package cpu_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t NOP_INSTR = 16'h0000;

endpackage

// File: rtl/ir_queue.sv
// Instruction register queue between fetch and decode.
// FIFO of DEPTH words with valid/ready on both sides and flush.
module ir_queue
    import cpu_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [WIDTH-1:0] D_in,
    input  logic             w_valid,
    output logic             w_ready,
    output logic [WIDTH-1:0] r,
    output logic             r_valid,
    input  logic             r_ready,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    // Handshake qualifiers and outputs, all from registered state
    always_comb begin
        w_ready = (count != CNT_FULL);
        r_valid = (count != '0);
        push    = w_valid & w_ready;
        pop     = r_valid & r_ready;
        r       = r_valid ? mem[rd_ptr] : '0;
    end

    // Storage is only written on an accepted, non-flushed push
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= D_in;
        end
    end

    // Pointer and occupancy update; flush overrides push and pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule
